sha256_arbiter: RTL and testbench

SHA256_ARBITER -- requirements
Module: sha256_arbiter

---
 rtl/sha256_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sha256_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that locks one requester onto the shared SHA-256 manager for a whole message and digest return (optional per-requester message counters under SHA256_ARB_STATS_EN).
// Latency: one cycle of arbitration from IDLE to DATA; data and digest paths are purely combinational pass-through.
// Backpressure: manager ready and granted requester's digest ready are forwarded straight through; non-granted requesters always see ready/valid low.
module sha256_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SHA_IF_DATA_W   = 256,
  parameter int SHA256_DIGEST_W = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_arb_data_val,
  input  logic [NUM_REQ*SHA_IF_DATA_W-1:0]   req_arb_data,
  input  logic [NUM_REQ-1:0]                 req_arb_data_last,
  output logic [NUM_REQ-1:0]                 arb_req_rdy,
  output logic [NUM_REQ-1:0]                 arb_req_digest_val,
  output logic [SHA256_DIGEST_W-1:0]         arb_req_digest,
  input  logic [NUM_REQ-1:0]                 req_arb_digest_rdy,
  output logic                               arb_mgr_data_val,
  output logic [SHA_IF_DATA_W-1:0]           arb_mgr_data,
  output logic                               arb_mgr_data_last,
  input  logic                               mgr_arb_rdy,
  input  logic                               mgr_arb_digest_val,
  input  logic [SHA256_DIGEST_W-1:0]         mgr_arb_digest,
  output logic                               arb_mgr_digest_rdy,
  output logic [2:0]                         arb_grant_id,
  output logic                               arb_busy
`ifdef SHA256_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]              arb_msg_count
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, DIGEST} state_t;

  state_t             state, state_nxt;
  logic [2:0]         grant, grant_nxt;
  logic [2:0]         rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0] gnt_oh;
  logic               g_val;
  logic               g_last;
  logic               g_dig_rdy;
  logic [SHA_IF_DATA_W-1:0] g_data;

  logic               sel_found;
  logic [2:0]         sel_id;
  int                 idx;

  logic               data_hs;
  logic               dig_hs;

  // Everything the granted requester drives, muxed out by the registered grant.
  always_comb begin
    gnt_oh    = '0;
    g_val     = 1'b0;
    g_last    = 1'b0;
    g_dig_rdy = 1'b0;
    g_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        g_val     = req_arb_data_val[i];
        g_last    = req_arb_data_last[i];
        g_dig_rdy = req_arb_digest_rdy[i];
        g_data    = req_arb_data[i*SHA_IF_DATA_W +: SHA_IF_DATA_W];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!sel_found && idx == k && req_arb_data_val[k]) begin
          sel_found = 1'b1;
          sel_id    = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    rr_ptr_nxt         = rr_ptr;
    arb_req_rdy        = '0;
    arb_req_digest_val = '0;
    arb_mgr_data_val   = 1'b0;
    arb_mgr_data_last  = 1'b0;
    arb_mgr_digest_rdy = 1'b0;
    arb_mgr_data       = g_data;
    arb_req_digest     = mgr_arb_digest;
    data_hs            = 1'b0;
    dig_hs             = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = sel_id;
          state_nxt = DATA;
        end
      end
      DATA: begin
        arb_mgr_data_val  = g_val;
        arb_mgr_data_last = g_last;
        arb_req_rdy       = gnt_oh & {NUM_REQ{mgr_arb_rdy}};
        data_hs           = g_val & mgr_arb_rdy;
        if (data_hs && g_last) state_nxt = DIGEST;
      end
      DIGEST: begin
        arb_req_digest_val = gnt_oh & {NUM_REQ{mgr_arb_digest_val}};
        arb_mgr_digest_rdy = g_dig_rdy;
        dig_hs             = mgr_arb_digest_val & g_dig_rdy;
        if (dig_hs) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == 3'(NUM_REQ - 1)) ? 3'd0 : grant + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb_grant_id = grant;
  assign arb_busy     = (state != IDLE);

`ifdef SHA256_ARB_STATS_EN
  logic [15:0] msg_cnt [NUM_REQ];

  // Counts saturate rather than wrap so a long soak never reports a small number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) msg_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (dig_hs && gnt_oh[i] && msg_cnt[i] != 16'hFFFF) msg_cnt[i] <= msg_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    arb_msg_count = '0;
    for (int i = 0; i < NUM_REQ; i++) arb_msg_count[i*16 +: 16] = msg_cnt[i];
  end
`endif

endmodule

// File: tb/tb_sha256_arbiter.sv
// Scoreboard bench for sha256_arbiter: stimulus pushes expected words/digests, a negedge monitor pops and compares on every handshake.
module tb_sha256_arbiter;
  localparam int N = 4;
  localparam int W = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_arb_data_val;
  logic [N*W-1:0]   req_arb_data;
  logic [N-1:0]     req_arb_data_last;
  logic [N-1:0]     arb_req_rdy;
  logic [N-1:0]     arb_req_digest_val;
  logic [W-1:0]     arb_req_digest;
  logic [N-1:0]     req_arb_digest_rdy;
  logic             arb_mgr_data_val;
  logic [W-1:0]     arb_mgr_data;
  logic             arb_mgr_data_last;
  logic             mgr_arb_rdy;
  logic             mgr_arb_digest_val;
  logic [W-1:0]     mgr_arb_digest;
  logic             arb_mgr_digest_rdy;
  logic [2:0]       arb_grant_id;
  logic             arb_busy;
`ifdef SHA256_ARB_STATS_EN
  logic [N*16-1:0]  arb_msg_count;
`endif

  sha256_arbiter #(.NUM_REQ(N), .SHA_IF_DATA_W(W), .SHA256_DIGEST_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_arb_data_val(req_arb_data_val), .req_arb_data(req_arb_data),
    .req_arb_data_last(req_arb_data_last), .arb_req_rdy(arb_req_rdy),
    .arb_req_digest_val(arb_req_digest_val), .arb_req_digest(arb_req_digest),
    .req_arb_digest_rdy(req_arb_digest_rdy),
    .arb_mgr_data_val(arb_mgr_data_val), .arb_mgr_data(arb_mgr_data),
    .arb_mgr_data_last(arb_mgr_data_last), .mgr_arb_rdy(mgr_arb_rdy),
    .mgr_arb_digest_val(mgr_arb_digest_val), .mgr_arb_digest(mgr_arb_digest),
    .arb_mgr_digest_rdy(arb_mgr_digest_rdy), .arb_grant_id(arb_grant_id),
    .arb_busy(arb_busy)
`ifdef SHA256_ARB_STATS_EN
    , .arb_msg_count(arb_msg_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   id;
    logic [W-1:0] dat;
    logic         last;
  } exp_t;

  exp_t dq[$];
  exp_t gq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(ref exp_t q[$], input int id, input logic [W-1:0] d, input logic last);
    exp_t e;
    e.id = 3'(id); e.dat = d; e.last = last;
    q.push_back(e);
  endtask

  // Monitor: every manager-side data handshake and every requester digest handshake is scored.
  always @(negedge clk) begin
    if (rst) begin
      if (arb_mgr_data_val && mgr_arb_rdy) begin
        if (dq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL data_unexpected: got word %0h required none", arb_mgr_data);
        end else begin
          exp_t e;
          e = dq.pop_front();
          chk("data_word", arb_mgr_data, e.dat);
          chk("data_last", W'(arb_mgr_data_last), W'(e.last));
          chk("data_grant", W'(arb_grant_id), W'(e.id));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (arb_req_digest_val[i] && req_arb_digest_rdy[i]) begin
          if (gq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL digest_unexpected: got req %0d required none", i);
          end else begin
            exp_t g;
            g = gq.pop_front();
            chk("digest_req", W'(i), W'(g.id));
            chk("digest_val", arb_req_digest, g.dat);
          end
        end
      end
    end
  end

  task automatic put_word(input int id, input logic [W-1:0] d, input logic last);
    req_arb_data_val[id]      = 1'b1;
    req_arb_data[id*W +: W]   = d;
    req_arb_data_last[id]     = last;
  endtask

  task automatic wait_data_hs(input int id);
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_arb_data_val[id] && arb_req_rdy[id]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL data_timeout: got no handshake for req %0d required one", id);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_dig_hs(input int id);
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (arb_req_digest_val[id] && req_arb_digest_rdy[id]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL digest_timeout: got no handshake for req %0d required one", id);
    end
    @(posedge clk); #1;
  endtask

  task automatic one_msg(input int id, input logic [W-1:0] d, input logic [W-1:0] dig);
    push(dq, id, d, 1'b1);
    put_word(id, d, 1'b1);
    wait_data_hs(id);
    req_arb_data_val[id] = 1'b0;
    push(gq, id, dig, 1'b1);
    mgr_arb_digest        = dig;
    mgr_arb_digest_val    = 1'b1;
    req_arb_digest_rdy[id] = 1'b1;
    wait_dig_hs(id);
    mgr_arb_digest_val = 1'b0;
    req_arb_digest_rdy = '0;
  endtask

  task automatic clear_inputs();
    req_arb_data_val   = '0;
    req_arb_data       = '0;
    req_arb_data_last  = '0;
    req_arb_digest_rdy = '0;
    mgr_arb_rdy        = 1'b1;
    mgr_arb_digest_val = 1'b0;
    mgr_arb_digest     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int           ord [4];
  logic [W-1:0] rdig [4];

  initial begin
    ord  = '{0, 1, 3, 0};
    rdig = '{256'hD0, 256'hD1, 256'hD2, 256'hD3};
    rst = 1'b0;
    clear_inputs();
    #2;
    chk("rst_req_rdy",     W'(arb_req_rdy), '0);
    chk("rst_digest_val",  W'(arb_req_digest_val), '0);
    chk("rst_mgr_val",     W'(arb_mgr_data_val), '0);
    chk("rst_mgr_dig_rdy", W'(arb_mgr_digest_rdy), '0);
    chk("rst_grant_id",    W'(arb_grant_id), '0);
    chk("rst_busy",        W'(arb_busy), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single requester, two-word message.
    push(dq, 2, 256'hA1, 1'b0);
    push(dq, 2, 256'hA2, 1'b1);
    put_word(2, 256'hA1, 1'b0);
    wait_data_hs(2);
    put_word(2, 256'hA2, 1'b1);
    wait_data_hs(2);
    req_arb_data_val[2] = 1'b0;
    push(gq, 2, 256'hDD01, 1'b1);
    mgr_arb_digest = 256'hDD01; mgr_arb_digest_val = 1'b1; req_arb_digest_rdy[2] = 1'b1;
    wait_dig_hs(2);
    mgr_arb_digest_val = 1'b0; req_arb_digest_rdy = '0;
    @(negedge clk);
    chk("idle_after_digest", W'(arb_busy), '0);

    // rr_ptr is now 3: with req 0 and req 3 both valid, req 3 wins.
    @(posedge clk); #1;
    put_word(0, 256'hBAD0, 1'b1);
    one_msg(3, 256'hC3, 256'hDD02);
    req_arb_data_val = '0;

    // Round robin with 0, 1, 3 continuously valid.
    do_reset();
    push(dq, 0, 256'hE0, 1'b1); push(dq, 1, 256'hE1, 1'b1);
    push(dq, 3, 256'hE3, 1'b1); push(dq, 0, 256'hE4, 1'b1);
    for (int r = 0; r < 4; r++) push(gq, ord[r], rdig[r], 1'b1);
    put_word(0, 256'hE0, 1'b1); put_word(1, 256'hE1, 1'b1); put_word(3, 256'hE3, 1'b1);
    req_arb_digest_rdy = '1; mgr_arb_digest_val = 1'b1;
    for (int r = 0; r < 4; r++) begin
      mgr_arb_digest = rdig[r];
      wait_data_hs(ord[r]);
      if (r == 0) put_word(0, 256'hE4, 1'b1);
      wait_dig_hs(ord[r]);
    end
    clear_inputs();

    // Manager backpressure for 5 cycles; req 2 valid but not granted (rr_ptr = 1).
    mgr_arb_rdy = 1'b0;
    put_word(1, 256'hF1, 1'b1);
    put_word(2, 256'hF2, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_req_rdy", W'(arb_req_rdy), '0);
      chk("bp_word_held", arb_mgr_data, 256'hF1);
      chk("bp_mgr_val", W'(arb_mgr_data_val), W'(1'b1));
    end
    @(posedge clk); #1;
    push(dq, 1, 256'hF1, 1'b1);
    mgr_arb_rdy = 1'b1;
    wait_data_hs(1);
    req_arb_data_val[1] = 1'b0;

    // Digest stall: granted req 1 not ready, non-granted req 2 ready.
    mgr_arb_digest = 256'hDD03; mgr_arb_digest_val = 1'b1; req_arb_digest_rdy = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_mgr_dig_rdy", W'(arb_mgr_digest_rdy), '0);
      chk("stall_busy", W'(arb_busy), W'(1'b1));
      chk("stall_digest_val", W'(arb_req_digest_val), W'(4'b0010));
    end
    @(posedge clk); #1;
    push(gq, 1, 256'hDD03, 1'b1);
    req_arb_digest_rdy = 4'b0110;
    wait_dig_hs(1);
    req_arb_data_val = '0; mgr_arb_digest_val = 1'b0; req_arb_digest_rdy = '0;
    @(negedge clk);
    chk("stall_idle_after", W'(arb_busy), '0);

    // Reset after word 1 of a 3-word message from req 3 (rr_ptr = 2).
    @(posedge clk); #1;
    push(dq, 3, 256'h31, 1'b0);
    put_word(3, 256'h31, 1'b0);
    wait_data_hs(3);
    put_word(3, 256'h32, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_mgr_val", W'(arb_mgr_data_val), '0);
    chk("arst_req_rdy", W'(arb_req_rdy), '0);
    chk("arst_busy", W'(arb_busy), '0);
    chk("arst_grant_id", W'(arb_grant_id), '0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("arst_idle", W'(arb_busy), '0);
    @(posedge clk); #1;
    put_word(3, 256'hBAD3, 1'b1);
    one_msg(0, 256'h40, 256'hDD04);
    req_arb_data_val = '0;

`ifdef SHA256_ARB_STATS_EN
    do_reset();
    one_msg(0, 256'h50, 256'hDD05);
    one_msg(0, 256'h51, 256'hDD06);
    one_msg(0, 256'h52, 256'hDD07);
    @(negedge clk);
    chk("stats_req0", W'(arb_msg_count[15:0]), W'(16'd3));
    chk("stats_others", W'(arb_msg_count[N*16-1:16]), '0);
`endif

    repeat (3) @(negedge clk);
    chk("data_queue_drained", W'(dq.size()), '0);
    chk("digest_queue_drained", W'(gq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required finish before 200000");
    $fatal(1);
  end

endmodule
